binary_mul_3x3_uni: RTL and testbench

- 3-bit x 3-bit unsigned multiplier with a single registered output stage (1-cycle latency).
- Leaf arithmetic block: combinational array-multiplier core feeding a 6-bit product register, gated by a clock enable.
- Used wherever a small unsigned product is needed with a registered, reset-clean result.

---
 rtl/binary_mul_3x3_uni.sv | 63 ++++++
 tb/tb_binary_mul_3x3_uni.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/binary_mul_3x3_uni.sv
// 3x3 unsigned array multiplier with a single enabled, async-reset product register.
// P is driven only by the register, so it is glitch-free and zero out of reset.
module binary_mul_3x3_uni (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [2:0] A,
  input  logic [2:0] B,
  output logic [5:0] P
);

  // Adder cells return {carry, sum}.
  function automatic logic [1:0] half_add(input logic x, input logic y);
    half_add = {x & y, x ^ y};
  endfunction

  function automatic logic [1:0] full_add(input logic x, input logic y, input logic z);
    full_add = {(x & y) | (x & z) | (y & z), x ^ y ^ z};
  endfunction

  logic [2:0] pp_s [3];
  logic [1:0] c1_s, c2_s, c3_s, c4_s, c5_s, c6_s;
  logic [5:0] prod_s;
  logic [5:0] p_d, p_q;

  // Partial products pp_s[i][j] = A[j] & B[i] reduced by two rows of adders.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      pp_s[i] = A & {3{B[i]}};
    end
    // Row 1: A*B[0] plus (A*B[1] << 1)
    c1_s = half_add(pp_s[0][1], pp_s[1][0]);
    c2_s = full_add(pp_s[0][2], pp_s[1][1], c1_s[1]);
    c3_s = half_add(pp_s[1][2], c2_s[1]);
    // Row 2: add (A*B[2] << 2)
    c4_s = half_add(c2_s[0], pp_s[2][0]);
    c5_s = full_add(c3_s[0], pp_s[2][1], c4_s[1]);
    c6_s = full_add(c3_s[1], pp_s[2][2], c5_s[1]);
    prod_s = {c6_s[1], c6_s[0], c5_s[0], c4_s[0], c1_s[0], pp_s[0][0]};
  end

  // Next product: load on enable, otherwise hold.
  always_comb begin
    p_d = p_q;
    if (en) begin
      p_d = prod_s;
    end else begin
      p_d = p_q;
    end
  end

  // Product register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q <= 6'd0;
    end else begin
      p_q <= p_d;
    end
  end

  assign P = p_q;

endmodule

// File: tb/tb_binary_mul_3x3_uni.sv
// Self-checking bench for binary_mul_3x3_uni: directed plan plus randomized
// enable/operand traffic compared against an arithmetic reference model.
module tb_binary_mul_3x3_uni;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [2:0] A;
  logic [2:0] B;
  logic [5:0] P;

  int n_vec;
  int n_err;
  int exp_p;

  binary_mul_3x3_uni dut (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .A    (A),
    .B    (B),
    .P    (P)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [5:0] obs, input int expv);
    n_vec++;
    if (obs !== expv[5:0]) begin
      n_err++;
      $display("FAIL %s: got %0d (%b) expected %0d", tag, obs, obs, expv);
    end
  endtask

  task automatic drive(input logic e, input int a, input int b);
    @(negedge clk);
    en = e;
    A  = a[2:0];
    B  = b[2:0];
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int a_vals[5];
    int b_vals[5];
    int ra, rb;
    logic re;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    en    = 1'b0;
    A     = 3'd5;
    B     = 3'd6;

    // Reset holds P at zero while the clock runs, even with en high.
    repeat (2) begin
      after_edge();
      check_eq("reset_hold", P, 0);
    end
    en = 1'b1;
    after_edge();
    check_eq("reset_hold_en", P, 0);

    // Release between edges, then load 6*7=42 and reset asynchronously.
    drive(1'b1, 6, 7);
    rst_n = 1'b1;
    after_edge();
    check_eq("load_42", P, 42);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_clear", P, 0);
    rst_n = 1'b1;

    // Exhaustive sweep.
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        drive(1'b1, a, b);
        after_edge();
        check_eq($sformatf("sweep_%0dx%0d", a, b), P, a * b);
      end
    end

    // Latency: old value before the edge, new value after; mid-cycle change ignored.
    drive(1'b1, 1, 5);
    after_edge();
    drive(1'b1, 7, 7);
    #2;
    check_eq("lat_before", P, 5);
    after_edge();
    check_eq("lat_after", P, 49);
    #2;
    A = 3'd2;
    B = 3'd3;
    #1;
    check_eq("lat_midcycle", P, 49);
    after_edge();
    check_eq("lat_next", P, 6);

    // Enable hold.
    drive(1'b1, 4, 5);
    after_edge();
    check_eq("hold_load", P, 20);
    drive(1'b0, 7, 6);
    repeat (3) begin
      after_edge();
      check_eq("hold", P, 20);
    end
    drive(1'b1, 7, 6);
    after_edge();
    check_eq("hold_release", P, 42);

    // Reset release with en already high.
    drive(1'b1, 6, 3);
    rst_n = 1'b0;
    #1;
    check_eq("rel_in_reset", P, 0);
    after_edge();
    check_eq("rel_in_reset_edge", P, 0);
    @(negedge clk);
    rst_n = 1'b1;
    after_edge();
    check_eq("rel_first", P, 18);

    // Boundaries.
    a_vals = '{7, 0, 1, 7, 4};
    b_vals = '{0, 7, 7, 1, 4};
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, a_vals[k], b_vals[k]);
      after_edge();
      check_eq($sformatf("bound_%0dx%0d", a_vals[k], b_vals[k]), P, a_vals[k] * b_vals[k]);
    end

    // Random traffic: model keeps the last product loaded under enable.
    exp_p = 16;
    for (int n = 0; n < 300; n++) begin
      ra = $urandom_range(7, 0);
      rb = $urandom_range(7, 0);
      re = ($urandom_range(3, 0) != 0);
      drive(re, ra, rb);
      if (re) exp_p = ra * rb;
      after_edge();
      check_eq("random", P, exp_p);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
